// File: rtl/arts_prod_accum.sv
// Streaming accumulator for approximate-multiplier products.
// Collects 16-bit product beats into a saturating sum and a saturating beat
// count, then holds the result until the consumer accepts it.
module arts_prod_accum #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic {ACC, DONE} state_t;

  state_t state, state_nx;

  logic [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             sat, sat_nx;

  logic             take;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W:0]   cnt_ext;

  // Widened adders: the extra top bit is the overflow that triggers clamping.
  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W-15){1'b0}}, in_prod};
    cnt_ext = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  end

  // Next-state and handshake outputs; in_ready depends on state only.
  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    cnt_nx    = cnt;
    sat_nx    = sat;
    in_ready  = (state == ACC);
    out_valid = (state == DONE);
    take      = in_valid && in_ready;
    case (state)
      ACC: begin
        if (take) begin
          acc_nx = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
          cnt_nx = cnt_ext[CNT_W] ? '1 : cnt_ext[CNT_W-1:0];
          sat_nx = sat | sum_ext[ACC_W] | cnt_ext[CNT_W];
          if (in_last) state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_nx   = '0;
          cnt_nx   = '0;
          sat_nx   = 1'b0;
          state_nx = ACC;
        end
      end
      default: state_nx = ACC;
    endcase
  end

  // State and datapath registers; reset overrides any transfer or handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      sat   <= sat_nx;
    end
  end

  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_sat   = sat;

endmodule

// File: tb/tb_arts_prod_accum.sv
// Scoreboard bench for arts_prod_accum: stimulus pushes expected results,
// a monitor pops and compares them on each result handshake.
module tb_arts_prod_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic [7:0]  out_count;
  logic        out_sat;

  typedef struct {
    logic [23:0] sum;
    logic [7:0]  cnt;
    logic        sat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  arts_prod_accum #(.ACC_W(24), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [23:0] s, input logic [7:0] c, input logic st);
    exp_t e;
    e.sum = s;
    e.cnt = c;
    e.sat = st;
    exp_q.push_back(e);
  endtask

  // Offer one beat, waiting (bounded) for in_ready, and return #1 after the transfer edge.
  task automatic beat(input logic [15:0] p, input logic last);
    int n;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Monitor: compare on every result handshake; flag any result nobody expected.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 32'd0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check("mon_sum",   32'(out_sum),   32'(e.sum));
          check("mon_count", 32'(out_count), 32'(e.cnt));
          check("mon_sat",   32'(out_sat),   32'(e.sat));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_sat",   32'(out_sat),   32'd0);

    // Basic vector: 0x0100 + 0x00FF + 0xFFFF = 0x0101FE
    push_exp(24'h0101FE, 8'd3, 1'b0);
    beat(16'h0100, 1'b0);
    beat(16'h00FF, 1'b0);
    beat(16'hFFFF, 1'b1);
    check("basic_valid_lat1", 32'(out_valid), 32'd1);
    check("basic_ready_low",  32'(in_ready),  32'd0);
    @(posedge clk); #1;
    check("basic_valid_clear", 32'(out_valid), 32'd0);
    check("basic_ready_back",  32'(in_ready),  32'd1);
    drain("basic");

    // Backpressure: held result stays constant
    out_ready = 1'b0;
    push_exp(24'h001234, 8'd1, 1'b0);
    beat(16'h1234, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum",   32'(out_sum),   32'h1234);
      check("bp_ready", 32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_clear", 32'(out_valid), 32'd0);
    check("bp_sum_clear",   32'(out_sum),   32'd0);
    drain("bp");

    // Sum saturation: 300 x 0xFFFF
    push_exp(24'hFFFFFF, 8'hFF, 1'b1);
    for (int i = 0; i < 300; i++) beat(16'hFFFF, (i == 299));
    drain("sum_sat");

    // Count saturation: 260 x 1
    push_exp(24'h000104, 8'd255, 1'b1);
    for (int i = 0; i < 260; i++) beat(16'h0001, (i == 259));
    drain("cnt_sat");

    // Gaps: data offered with in_valid low must be ignored
    push_exp(24'd21, 8'd3, 1'b0);
    in_valid = 1'b1; in_prod = 16'd5;   in_last = 1'b0; @(posedge clk); #1;
    in_valid = 1'b0; in_prod = 16'd100; in_last = 1'b1; @(posedge clk); #1;
    in_valid = 1'b1; in_prod = 16'd7;   in_last = 1'b0; @(posedge clk); #1;
    in_valid = 1'b0; in_prod = 16'd200; in_last = 1'b1; @(posedge clk); #1;
    beat(16'd9, 1'b1);
    drain("gaps");

    // Reset mid-vector discards the partial sum
    beat(16'h0010, 1'b0);
    beat(16'h0010, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_sum",   32'(out_sum),   32'd0);
    check("midrst_count", 32'(out_count), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    push_exp(24'd3, 8'd1, 1'b0);
    beat(16'h0003, 1'b1);
    drain("midrst");

    // Zero-valued single beat still counts
    push_exp(24'd0, 8'd1, 1'b0);
    beat(16'h0000, 1'b1);
    drain("zero_beat");

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arts_prod_accum.md
ARTS_PROD_ACCUM -- requirements
Module: arts_prod_accum

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ACC_W, default 24, accumulator and result width in bits (ACC_W >= 17).
REQ-002 The block SHALL have parameter CNT_W, default 8, beat-counter width in bits.
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, a product beat is offered.
REQ-006 The block SHALL have port in_ready, output, 1, the block can accept a beat.
REQ-007 The block SHALL have port in_prod, input, 16, unsigned 16-bit product from the n=8 approximate multiplier.
REQ-008 The block SHALL have port in_last, input, 1, final beat of the current dot-product vector.
REQ-009 The block SHALL have port out_valid, output, 1, a result is held.
REQ-010 The block SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-011 The block SHALL have port out_sum, output, ACC_W, the accumulated sum.
REQ-012 The block SHALL have port out_count, output, CNT_W, the number of beats in the vector.
REQ-013 The block SHALL have port out_sat, output, 1, the sum or the count saturated during the vector.

Function
REQ-014 The block SHALL implement a two-state FSM: ACC (collecting beats) and DONE (holding the result).
REQ-015 in_ready SHALL be 1 in ACC and 0 in DONE, with no combinational path from out_ready to in_ready.
REQ-016 A beat SHALL transfer only in a cycle where in_valid && in_ready are both 1; in_prod and in_last are ignored otherwise.
REQ-017 On each transfer, acc SHALL become min(acc + in_prod, 2^ACC_W - 1), unsigned, with in_prod zero-extended.
REQ-018 On each transfer, cnt SHALL become min(cnt + 1, 2^CNT_W - 1).
REQ-019 If either clamp in REQ-017 or REQ-018 takes effect, the sticky flag sat SHALL be set, and it SHALL stay set until the result is consumed or rst is asserted.
REQ-020 A beat with in_prod = 0 SHALL still be counted.
REQ-021 A transfer with in_last = 1 SHALL update acc, cnt and sat as normal and move the FSM to DONE.
REQ-022 out_valid SHALL be 1 in the cycle after the last beat is accepted, giving a latency of 1 cycle.
REQ-023 out_sum, out_count and out_sat SHALL be driven directly from the registers acc, cnt and sat.
REQ-024 out_sum, out_count and out_sat SHALL be stable while out_valid = 1.
REQ-025 out_valid SHALL be 0 in ACC.
REQ-026 In DONE, when out_ready = 1, the block SHALL, on that clock edge:
  - clear acc, cnt and sat to 0;
  - return to ACC;
  - deassert out_valid in the next cycle.
REQ-027 Back-to-back vectors SHALL incur a 1-cycle bubble: in_ready = 0 in DONE, so the first beat of the next vector is accepted at the earliest one cycle after the result handshake.
REQ-028 If out_ready stays 0, DONE SHALL be held indefinitely with no change to any output.
REQ-029 A single-beat vector (in_last = 1 on the first beat) SHALL give out_count = 1 and out_sum = in_prod.
REQ-030 The block SHALL impose no maximum vector length: once cnt reaches 2^CNT_W - 1 it holds that value and sat is set.
REQ-031 in_prod SHALL be treated as opaque data; no correction or rounding is applied to the multiplier's approximate low bits.

Reset
REQ-032 While rst = 1 at a clock edge, the block SHALL force the FSM to ACC and set acc = 0, cnt = 0 and sat = 0.
REQ-033 The resulting reset output values SHALL be: in_ready = 1, out_valid = 0, out_sum = 0, out_count = 0, out_sat = 0.
REQ-034 rst SHALL take priority over any simultaneous transfer or handshake.
REQ-035 An rst asserted mid-vector, or while in DONE, SHALL discard partial or held results, with no out_valid pulse.
REQ-036 rst SHALL take effect only at a clock edge.

Verification
REQ-037 The bench SHALL cover a basic vector: beats 0x0100, 0x00FF, 0xFFFF (last=1 on the third), out_ready = 1 -> one cycle later out_valid = 1, out_sum = 0x0101FE, out_count = 3, out_sat = 0; the next cycle out_valid = 0 and in_ready = 1.
REQ-038 The bench SHALL cover backpressure: a single beat 0x1234 with last=1 and out_ready = 0 for 5 cycles -> out_valid = 1 and out_sum = 0x001234 are held constant, and in_ready = 0 throughout; on out_ready = 1 they clear next cycle.
REQ-039 The bench SHALL cover sum saturation: 300 beats of 0xFFFF, last on the 300th -> out_sum = 0xFFFFFF, out_count = 0xFF, out_sat = 1.
REQ-040 The bench SHALL cover count saturation: 260 beats of 0x0001 -> out_sum = 260 (0x000104), out_count = 255, out_sat = 1.
REQ-041 The bench SHALL cover gaps: in_valid toggling 1,0,1,0,1 with beats 5, 7, 9 (last=1 on 9) -> out_sum = 21, out_count = 3; beats offered while in_valid = 0 are not counted.
REQ-042 The bench SHALL cover reset mid-vector: after 2 beats of 0x0010, assert rst for 1 cycle, then send one beat 0x0003 with last=1 -> out_sum = 3, out_count = 1, out_sat = 0, and no out_valid before that beat.
